hamming_receptor: RTL and testbench
===================================

# hamming_receptor

Serial receive stage directly downstream of the `hamming` encoder/transmitter. It deserializes 8-bit extended Hamming(8,4) codewords from a UART-style line and decodes them with SEC-DED. The decoded nibble and a status code are presented on a valid/ready output register. Saturating counters track corrected and uncorrectable frames for the display stage.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be ≥ 2 and even.
- CNT_W, 8: width of the error counters.

Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rx  in  1  serial line, asynchronous to clk, idles high.
- dado  out  4  decoded data nibble, valid while out_valid is high.
- status  out  2  decode status: 0 = OK, 1 = CORR (single error corrected), 2 = UNCORR (double error).
- out_valid  out  1  output register holds an unread frame.
- out_ready  in  1  consumer accepts the frame in any cycle where both out_valid and out_ready are high.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  sticky; set when a good frame completes while out_valid is still high.
- clr  in  1  clears both counters and overrun.
- n_corr  out  CNT_W  count of CORR frames, saturating.
- n_uncorr  out  CNT_W  count of UNCORR frames, saturating.

## Operation
- **Input sync:** rx passes through a 2-FF synchronizer. Both flops reset to 1.
- **Start detection:** a start is a 1→0 transition on the synchronized line.
- **Frame format:** start bit (0), 8 codeword bits c0..c7 sent LSB first, stop bit (1).
- **Codeword mapping:** c0=p1, c1=p2, c2=d1, c3=p4, c4=d2, c5=d3, c6=d4, c7=p0. dado = {d4, d3, d2, d1}. p0 gives even parity over all 8 bits.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on the falling edge.
  - START: sample at CLKS_PER_BIT/2. If the sample is 1, it is a false start → IDLE. If 0 → DATA.
  - DATA: sample each bit CLKS_PER_BIT cycles after the previous sample. Use a 3-bit bit index; after bit 7 → STOP.
  - STOP: sample once. Return to IDLE in all cases.
- **Syndrome:**
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - s = {s4, s2, s1}; P = XOR of c0..c7.
- **Decode cases:**
  - s=0, P=0: OK.
  - s≠0, P=1: flip bit c[s-1], status CORR.
  - s=0, P=1: p0 in error, data unchanged, status CORR.
  - s≠0, P=0: status UNCORR; dado is the raw data bits, uncorrected.
- **Stop sample = 1 (good frame):**
  - If out_valid is low, or out_valid and out_ready are both high that cycle: load dado/status, set out_valid, update counters.
  - Otherwise: drop the frame, set overrun, leave counters unchanged.
- **Stop sample = 0:** pulse frame_err; no load, no counter update.
- **Counters:** increment by 1 and saturate at all-ones. If clr and an increment occur in the same cycle, clr wins.

## Timing
- **Reset values:** FSM = IDLE; all outputs 0 (dado, status, out_valid, frame_err, overrun, n_corr, n_uncorr); sync flops = 1.
- **Reset mid-frame:** the partial frame is discarded. Receive resumes only on a new 1→0 edge; a line held low through reset is not a start.
- **Sample points:** with the start edge seen at cycle T on the synchronized line:
  - start sample at T + CLKS_PER_BIT/2
  - bit k sample at T + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - stop sample at T + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- **Output latency:** out_valid rises the cycle after the stop sample. frame_err pulses in that same cycle.
- **Handshake:** out_valid stays high until accepted; dado/status are stable while out_valid is high. out_valid falls the cycle after acceptance, unless a new frame loads in that same cycle.
- **Back-to-back frames:** a new start edge is accepted the cycle after STOP returns to IDLE. The stop bit itself has full length on the line.

## Structure
- **Package `hamming_pkg`:**
  - codeword bit-position constants
  - status codes ST_OK / ST_CORR / ST_UNCORR
  - FSM state encodings
  - shared with the `hamming` encoder
- **Sub-module `hamming_secded_dec`:** purely combinational, 8-bit codeword in → {dado, status} out. Reusable by the encoder's self-check.
- **Top level:** synchronizer, FSM, bit and cycle counters, shift register, output register, and counters stay in `hamming_receptor`.

## Test plan
- **Clean frame:** send 8'h55 with out_ready=1 → dado=4'hB, status=OK, counters unchanged.
- **Single data-bit error:** send 8'h45 (c4 flipped) → dado=4'hB, status=CORR, n_corr=1.
- **p0 error:** send 8'hD5 (c7 flipped) → dado=4'hB, status=CORR.
- **Double error:** send 8'h56 (c0 and c1 flipped) → status=UNCORR, n_uncorr=1.
- **Overrun:** hold out_ready=0, send 8'h55 then 8'h45 → first frame retained, overrun=1, n_corr=0. Then assert clr → overrun=0.
- **Line faults:**
  - force stop bit to 0 → frame_err pulses once, out_valid stays 0
  - 1-cycle low glitch → false start, returns to IDLE with no output
  - assert reset mid-DATA → all outputs 0, next frame decodes correctly

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(8,4) encoder and receiver:
// codeword bit positions, decode status codes and receiver FSM states.
package hamming_pkg;

    localparam int unsigned CW_P1 = 0;
    localparam int unsigned CW_P2 = 1;
    localparam int unsigned CW_D1 = 2;
    localparam int unsigned CW_P4 = 3;
    localparam int unsigned CW_D2 = 4;
    localparam int unsigned CW_D3 = 5;
    localparam int unsigned CW_D4 = 6;
    localparam int unsigned CW_P0 = 7;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_CORR   = 2'd1,
        ST_UNCORR = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder for one extended Hamming(8,4) codeword.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] dado,
    output logic [1:0] status
);

    logic [2:0] syn;
    logic       par;
    logic [2:0] idx;
    logic [7:0] fixed;

    always_comb begin
        syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
        syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
        syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
        par    = ^code;
        idx    = syn - 3'd1;
        fixed  = code;
        status = ST_OK;
        if (syn != 3'd0 && par) begin
            fixed[idx] = ~code[idx];
            status     = ST_CORR;
        end else if (syn == 3'd0 && par) begin
            status = ST_CORR;
        end else if (syn != 3'd0 && !par) begin
            // Double error: data bits are passed through untouched.
            status = ST_UNCORR;
        end
        dado = {fixed[CW_D4], fixed[CW_D3], fixed[CW_D2], fixed[CW_D1]};
    end

endmodule

// File: rtl/hamming_receptor.sv
// UART-style receiver for extended Hamming(8,4) codewords with SEC-DED decode,
// valid/ready output register and saturating error counters.
module hamming_receptor
    import hamming_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [3:0]       dado,
    output logic [1:0]       status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr,
    output logic [CNT_W-1:0] n_corr,
    output logic [CNT_W-1:0] n_uncorr
);

    localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CYC_W-1:0] HALF = CYC_W'(CLKS_PER_BIT / 2);
    localparam logic [CYC_W-1:0] FULL = CYC_W'(CLKS_PER_BIT);

    rx_state_e        state_q;
    logic [1:0]       sync_q;
    logic [1:0]       armed_q;
    logic             rx_prev_q;
    logic [CYC_W-1:0] cyc_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    logic       rx_s;
    logic       start_edge;
    logic       stop_hit;
    logic       good;
    logic       load;
    logic [3:0] dec_dado;
    logic [1:0] dec_status;

    hamming_secded_dec u_dec (
        .code   (shift_q),
        .dado   (dec_dado),
        .status (dec_status)
    );

    // armed_q marks when sync_q[1] holds a real line sample, so a line held
    // low through reset never looks like a 1->0 edge.
    assign rx_s       = sync_q[1];
    assign start_edge = rx_prev_q & ~rx_s;
    assign stop_hit   = (state_q == StStop) && (cyc_q == FULL);
    assign good       = stop_hit & rx_s;
    assign load       = good & (~out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            armed_q   <= 2'b00;
            rx_prev_q <= 1'b0;
            cyc_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            dado      <= 4'd0;
            status    <= 2'd0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            n_corr    <= '0;
            n_uncorr  <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            armed_q   <= {armed_q[0], 1'b1};
            rx_prev_q <= armed_q[1] & rx_s;
            frame_err <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q <= StStart;
                        cyc_q   <= CYC_W'(1);
                    end
                end
                StStart: begin
                    if (cyc_q == HALF) begin
                        state_q <= rx_s ? StIdle : StData;
                        cyc_q   <= CYC_W'(1);
                        bit_q   <= 3'd0;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StData: begin
                    if (cyc_q == FULL) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cyc_q   <= CYC_W'(1);
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= StStop;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cyc_q == FULL) begin
                        state_q <= StIdle;
                        if (!rx_s) frame_err <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (load) begin
                dado      <= dec_dado;
                status    <= dec_status;
                out_valid <= 1'b1;
            end

            if (clr) begin
                n_corr   <= '0;
                n_uncorr <= '0;
                overrun  <= 1'b0;
            end else begin
                if (load && dec_status == ST_CORR && n_corr != '1) begin
                    n_corr <= n_corr + 1'b1;
                end
                if (load && dec_status == ST_UNCORR && n_uncorr != '1) begin
                    n_uncorr <= n_uncorr + 1'b1;
                end
                if (good && !load) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_receptor.sv
// Scoreboard bench for hamming_receptor: expected frames are queued when sent
// and compared when the output register is accepted.
module tb_hamming_receptor;

    localparam int unsigned CPB   = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [3:0] dado;
        logic [1:0] status;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             rx = 1'b1;
    logic [3:0]       dado;
    logic [1:0]       status;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             frame_err;
    logic             overrun;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] n_corr;
    logic [CNT_W-1:0] n_uncorr;

    int   n_checks = 0;
    int   n_errors = 0;
    int   fe_cnt = 0;
    int   exp_corr = 0;
    int   exp_uncorr = 0;
    exp_t sb_q[$];

    hamming_receptor #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .dado      (dado),
        .status    (status),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr       (clr),
        .n_corr    (n_corr),
        .n_uncorr  (n_uncorr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Nearest-codeword search, independent of the syndrome arithmetic.
    function automatic exp_t model(input logic [7:0] cw);
        exp_t e;
        e.dado   = {cw[6], cw[5], cw[4], cw[2]};
        e.status = 2'd2;
        for (int n = 0; n < 16; n++) begin
            if ($countones(cw ^ encode(4'(n))) == 0) begin
                e.dado   = 4'(n);
                e.status = 2'd0;
            end else if ($countones(cw ^ encode(4'(n))) == 1) begin
                e.dado   = 4'(n);
                e.status = 2'd1;
            end
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] cw, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = cw[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic expect_frame(input logic [7:0] cw);
        exp_t e;
        e = model(cw);
        sb_q.push_back(e);
        if (e.status == 2'd1) exp_corr++;
        if (e.status == 2'd2) exp_uncorr++;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_frame", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("dado", 32'(dado), 32'(e.dado));
                    check("status", 32'(status), 32'(e.status));
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cw;
        int         fe0;
        int         b0;
        int         b1;

        tick(3);
        check("rst_dado", 32'(dado), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_ncorr", 32'(n_corr), 32'd0);
        check("rst_nuncorr", 32'(n_uncorr), 32'd0);
        reset = 1'b0;
        tick(6);

        // Directed frames with hand-derived results.
        sb_q.push_back('{dado: 4'hB, status: 2'd0});
        send_frame(8'h55, 1'b1);
        check("clean_ncorr", 32'(n_corr), 32'd0);
        sb_q.push_back('{dado: 4'hB, status: 2'd1});
        send_frame(8'h45, 1'b1);
        check("c4_ncorr", 32'(n_corr), 32'd1);
        sb_q.push_back('{dado: 4'hB, status: 2'd1});
        send_frame(8'hD5, 1'b1);
        check("p0_ncorr", 32'(n_corr), 32'd2);
        sb_q.push_back('{dado: 4'hB, status: 2'd2});
        send_frame(8'h56, 1'b1);
        check("dbl_nuncorr", 32'(n_uncorr), 32'd1);
        exp_corr   = 2;
        exp_uncorr = 1;

        for (int k = 0; k < 12; k++) begin
            cw = encode(4'($urandom_range(0, 15)));
            b0 = $urandom_range(0, 7);
            b1 = (b0 + $urandom_range(1, 7)) % 8;
            if (k % 3 >= 1) cw[b0] = ~cw[b0];
            if (k % 3 == 2) cw[b1] = ~cw[b1];
            expect_frame(cw);
            send_frame(cw, 1'b1);
        end
        check("rand_ncorr", 32'(n_corr), 32'(exp_corr));
        check("rand_nuncorr", 32'(n_uncorr), 32'(exp_uncorr));

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_ncorr", 32'(n_corr), 32'd0);
        check("clr_nuncorr", 32'(n_uncorr), 32'd0);

        // Overrun: second frame arrives while the first is still unread.
        out_ready = 1'b0;
        sb_q.push_back('{dado: 4'hB, status: 2'd0});
        send_frame(8'h55, 1'b1);
        send_frame(8'h45, 1'b1);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_dado", 32'(dado), 32'hB);
        check("ovr_status", 32'(status), 32'd0);
        check("ovr_ncorr", 32'(n_corr), 32'd0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick(3);
        check("ovr_drained", 32'(out_valid), 32'd0);

        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_valid", 32'(out_valid), 32'd0);

        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_valid", 32'(out_valid), 32'd0);
        check("glitch_ferr", 32'(fe_cnt - fe0), 32'd1);
        sb_q.push_back('{dado: 4'hB, status: 2'd0});
        send_frame(8'h55, 1'b1);

        // Reset in the middle of a frame with a held frame and live counters.
        out_ready = 1'b0;
        send_frame(8'h56, 1'b1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_nunc", 32'(n_uncorr), 32'd1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
        rx = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dado", 32'(dado), 32'd0);
        check("mid_rst_status", 32'(status), 32'd0);
        check("mid_rst_nunc", 32'(n_uncorr), 32'd0);
        tick(12 * CPB);
        check("low_thru_rst", 32'(out_valid | frame_err), 32'd0);
        rx = 1'b1;
        out_ready = 1'b1;
        tick(4);
        sb_q.push_back('{dado: 4'hB, status: 2'd1});
        send_frame(8'h45, 1'b1);
        check("post_rst_ncorr", 32'(n_corr), 32'd1);

        tick(10);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
